mac_accumulator: RTL and testbench
==================================

Name: mac_accumulator

Overview:
- Stage directly downstream of the 4x4 signed shift-add multiplier.
- Consumes each 8-bit signed product, qualified by the multiplier's one-cycle done pulse, and accumulates N_TERMS products into a saturating sum.
- Presents each finished sum on a valid/ready result port.
- Back-pressures the upstream load sequencer through prod_ready, so dot products of multiplier results can be built without software glue.

Parameters:
- N_TERMS, 8, number of products summed per result (≥1).
- ACC_W, 10, accumulator/result width in bits, two's complement (≥9).
- CNT_W, 4, term-counter width; must satisfy 2**CNT_W > N_TERMS.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort: discard partial sum, return to IDLE.
- prod_valid  in  1  product strobe; wired to multiplier done.
- prod  in  8  signed product; wired to multiplier out.
- prod_ready  out  1  block can take a product this cycle; gates upstream load.
- res_valid  out  1  res_sum/res_ovf valid.
- res_ready  in  1  consumer accepts result.
- res_sum  out  ACC_W  signed accumulated sum.
- res_ovf  out  1  saturation occurred during this sum.
- term_cnt  out  CNT_W  products accepted into current sum.
- drop  out  1  sticky: a product arrived while prod_ready=0.

Behaviour:
- Reset (rst=0, async): state=IDLE, acc=0, term_cnt=0, res_valid=0, res_sum=0, res_ovf=0, drop=0.
- States: IDLE, ACCUM, HOLD.
- Accept condition: prod_valid & prod_ready.
- prod_ready is combinational: 1 in IDLE and ACCUM; in HOLD it equals res_ready.
- Arithmetic:
  - prod is sign-extended to ACC_W and added to acc.
  - If the true sum exceeds 2**(ACC_W-1)-1, or falls below -2**(ACC_W-1), acc clamps to that bound and an internal ovf flag sets.
  - ovf stays set until the sum is retired or cleared.
- IDLE, on accept: acc=sext(prod), term_cnt=1, ovf=0.
  - Next state is ACCUM if N_TERMS>1, else HOLD.
- ACCUM, on accept: acc=sat(acc+prod), term_cnt+1.
  - When the incremented count equals N_TERMS, go to HOLD.
  - No accept: hold all state. Idle gaps between products are unlimited.
- Entering HOLD:
  - res_sum and res_ovf are registered from the final acc and ovf.
  - res_valid=1 on the same edge, so the result is visible the cycle after the last accept.
- HOLD:
  - res_sum, res_ovf and res_valid stay stable until res_valid & res_ready.
  - Retire (res_ready=1) with no accept: res_valid=0, acc=0, term_cnt=0, next state IDLE.
  - Retire with a simultaneous accept: the product becomes term 1 of the next sum, exactly as the IDLE accept. Zero bubble; res_valid drops the same edge.
- drop: set on any cycle with prod_valid=1 & prod_ready=0. Cleared only by clear or reset. The dropped product does not alter acc.
- clear, from any state:
  - Next edge: IDLE, acc=0, term_cnt=0, res_valid=0, ovf=0, drop=0.
  - clear has priority over a simultaneous accept; that product is discarded and does not set drop.
  - A result pending in HOLD is discarded.
- Reset mid-sum or mid-HOLD: immediate return to reset values. No partial result is emitted.
- Width rules: term_cnt never exceeds N_TERMS. res_sum is never wider than ACC_W, and no wrap-around is ever emitted.

Decomposition:
- Shared package mac_pkg holds:
  - State encoding constants IDLE=2'b00, ACCUM=2'b01, HOLD=2'b10.
  - Default product width PROD_W=8, shared with the multiplier's out width.
- One sub-module is natural: sat_add, a combinational parameterised signed saturating adder.
  - Inputs: a[ACC_W], b[ACC_W].
  - Outputs: sum[ACC_W], ovf.

Test Plan:
- Basic sum: reset, feed products 3, -5, 10, 7, 0, 1, -2, 4 with gaps of 0–3 cycles, res_ready=1 → res_valid pulses one cycle after the 8th accept; res_sum=18, res_ovf=0; then prod_ready=1 and state IDLE.
- Positive saturation: eight products of 64 → res_sum=511, res_ovf=1. Then eight products of -56 → res_sum=-448, res_ovf=0 (ovf flag cleared per sum).
- Back-pressure: complete a sum with res_ready=0 for 5 cycles, and pulse prod_valid with 9 during HOLD → res_sum stable, prod_ready=0, drop=1, and 9 is absent from the next sum. Then raise res_ready together with prod_valid and prod=2 → the next sum's first term is 2, term_cnt=1.
- Clear mid-sum: accept 4 products, assert clear with prod_valid and prod=6 the same cycle → next cycle term_cnt=0, acc=0, drop=0. A following 8 products of 1 give res_sum=8.
- Async reset: drop rst low between clock edges while in ACCUM with term_cnt=5 → all outputs are 0 immediately, before the next edge. After release, a new sum completes normally.
- N_TERMS=1 build: each accepted product goes directly to HOLD; res_sum=sext(prod) on the next cycle; back-to-back products with res_ready=1 give a result every cycle.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the multiplier-fed MAC accumulator stage.
package mac_pkg;

  localparam int unsigned PROD_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    HOLD  = 2'b10
  } state_e;

endpackage

// File: rtl/sat_add.sv
// Combinational two's-complement adder that clamps to the representable range.
module sat_add #(
  parameter int unsigned ACC_W = 10
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W:0] full;

  // One guard bit: overflow iff the guard and sign bits disagree.
  always_comb begin
    full = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    sum  = full[ACC_W-1:0];
    ovf  = 1'b0;
    if (full[ACC_W] != full[ACC_W-1]) begin
      ovf = 1'b1;
      sum = full[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// Sums N_TERMS signed products into a saturating result offered on a valid/ready port,
// back-pressuring the upstream multiplier sequencer while a result is held.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int unsigned N_TERMS = 8,
  parameter int unsigned ACC_W   = 10,
  parameter int unsigned CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic              prod_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_sum,
  output logic              res_ovf,
  output logic [CNT_W-1:0]  term_cnt,
  output logic              drop
);

  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(N_TERMS);
  localparam state_e           FIRST_NEXT = (N_TERMS == 1) ? HOLD : ACCUM;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   term_cnt_q, term_cnt_d;
  logic               res_valid_q, res_valid_d;
  logic [ACC_W-1:0]   res_sum_q, res_sum_d;
  logic               res_ovf_q, res_ovf_d;
  logic               drop_q, drop_d;

  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   add_sum;
  logic               add_ovf;
  logic               accept;
  logic               start;

  assign prod_ext   = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign prod_ready = (state_q != HOLD) | res_ready;
  assign accept     = prod_valid & prod_ready;

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .a   (acc_q),
    .b   (prod_ext),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // Next-state: clear wins over everything; 'start' loads a product as term 1.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    term_cnt_d  = term_cnt_q;
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_ovf_d   = res_ovf_q;
    drop_d      = drop_q | (prod_valid & ~prod_ready);
    start       = 1'b0;

    if (clear) begin
      state_d     = IDLE;
      acc_d       = '0;
      ovf_d       = 1'b0;
      term_cnt_d  = '0;
      res_valid_d = 1'b0;
      drop_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: start = accept;
        ACCUM: begin
          if (accept) begin
            acc_d      = add_sum;
            ovf_d      = ovf_q | add_ovf;
            term_cnt_d = term_cnt_q + CNT_W'(1);
            if (term_cnt_d == LAST_CNT) begin
              state_d     = HOLD;
              res_valid_d = 1'b1;
              res_sum_d   = add_sum;
              res_ovf_d   = ovf_d;
            end
          end
        end
        HOLD: begin
          if (res_ready) begin
            state_d     = IDLE;
            acc_d       = '0;
            ovf_d       = 1'b0;
            term_cnt_d  = '0;
            res_valid_d = 1'b0;
            start       = prod_valid;
          end
        end
        default: state_d = IDLE;
      endcase

      if (start) begin
        state_d    = FIRST_NEXT;
        acc_d      = prod_ext;
        ovf_d      = 1'b0;
        term_cnt_d = CNT_W'(1);
        if (FIRST_NEXT == HOLD) begin
          res_valid_d = 1'b1;
          res_sum_d   = prod_ext;
          res_ovf_d   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      term_cnt_q  <= '0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_ovf_q   <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      term_cnt_q  <= term_cnt_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_ovf_q   <= res_ovf_d;
      drop_q      <= drop_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_ovf   = res_ovf_q;
  assign term_cnt  = term_cnt_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: default N_TERMS=8 build plus an N_TERMS=1 build.
module tb_mac_accumulator;

  typedef struct {
    int sum;
    int ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clear = 1'b0;
  logic       prod_valid = 1'b0;
  logic [7:0] prod = '0;
  logic       prod_ready;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [9:0] res_sum;
  logic       res_ovf;
  logic [3:0] term_cnt;
  logic       drop;

  logic       prod_valid1 = 1'b0;
  logic [7:0] prod1 = '0;
  logic       prod_ready1;
  logic       res_valid1;
  logic       res_ready1 = 1'b0;
  logic [9:0] res_sum1;
  logic       res_ovf1;
  logic [0:0] term_cnt1;
  logic       drop1;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_res    = 0;
  int   n_res1   = 0;
  exp_t exp_q[$];
  exp_t exp1_q[$];

  mac_accumulator #(.N_TERMS(8), .ACC_W(10), .CNT_W(4)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .prod_valid (prod_valid),
    .prod       (prod),
    .prod_ready (prod_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_ovf    (res_ovf),
    .term_cnt   (term_cnt),
    .drop       (drop)
  );

  mac_accumulator #(.N_TERMS(1), .ACC_W(10), .CNT_W(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .clear      (1'b0),
    .prod_valid (prod_valid1),
    .prod       (prod1),
    .prod_ready (prod_ready1),
    .res_valid  (res_valid1),
    .res_ready  (res_ready1),
    .res_sum    (res_sum1),
    .res_ovf    (res_ovf1),
    .term_cnt   (term_cnt1),
    .drop       (drop1)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic push(input int s, input int o);
    exp_t e;
    e.sum = s;
    e.ovf = o;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one product, hold it until accepted, then idle for 'gap' cycles.
  task automatic send(input logic signed [7:0] p, input int gap);
    int n = 0;
    prod_valid = 1'b1;
    prod       = p;
    @(negedge clk);
    while (!prod_ready) begin
      n++;
      if (n > 100) begin
        chk_eq("prod_ready_timeout", int'(prod_ready), 1);
        break;
      end
      @(negedge clk);
    end
    step();
    prod_valid = 1'b0;
    repeat (gap) step();
  endtask

  // Scoreboard pop on every result handshake.
  always @(negedge clk) begin
    if (rst && res_valid && res_ready) begin
      n_res++;
      chk_eq("sb_nonempty", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk_eq("res_sum", int'($signed(res_sum)), e.sum);
        chk_eq("res_ovf", int'(res_ovf), e.ovf);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && res_valid1 && res_ready1) begin
      n_res1++;
      chk_eq("sb1_nonempty", int'(exp1_q.size() > 0), 1);
      if (exp1_q.size() > 0) begin
        exp_t e;
        e = exp1_q.pop_front();
        chk_eq("n1_res_sum", int'($signed(res_sum1)), e.sum);
        chk_eq("n1_res_ovf", int'(res_ovf1), e.ovf);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vals1[4];
    vals1 = '{5, -7, 127, -128};

    res_ready = 1'b1;
    #3;
    chk_eq("rst_res_valid", int'(res_valid), 0);
    chk_eq("rst_res_sum", int'(res_sum), 0);
    chk_eq("rst_term_cnt", int'(term_cnt), 0);
    chk_eq("rst_drop", int'(drop), 0);
    chk_eq("rst_prod_ready", int'(prod_ready), 1);
    step();
    rst = 1'b1;

    // Basic sum with irregular gaps.
    push(18, 0);
    send(3, 1); send(-5, 0); send(10, 3); send(7, 2);
    send(0, 1); send(1, 0); send(-2, 2); send(4, 0);
    chk_eq("basic_valid", int'(res_valid), 1);
    chk_eq("basic_cnt", int'(term_cnt), 8);
    step();
    chk_eq("basic_retired", int'(res_valid), 0);
    chk_eq("basic_ready", int'(prod_ready), 1);
    chk_eq("basic_cnt0", int'(term_cnt), 0);

    // Positive saturation, then a fresh sum with ovf cleared.
    push(511, 1);
    repeat (8) send(64, 0);
    chk_eq("sat_ovf_direct", int'(res_ovf), 1);
    step();
    push(-448, 0);
    repeat (8) send(-56, 1);

    // Back-pressure: hold the result, drop a product, then zero-bubble restart.
    res_ready = 1'b0;
    push(36, 0);
    for (int i = 1; i <= 8; i++) send(8'(i), 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        prod_valid = 1'b1;
        prod       = 8'd9;
      end
      @(negedge clk);
      chk_eq("bp_prod_ready", int'(prod_ready), 0);
      chk_eq("bp_valid", int'(res_valid), 1);
      chk_eq("bp_sum_stable", int'($signed(res_sum)), 36);
      step();
      prod_valid = 1'b0;
    end
    chk_eq("bp_drop", int'(drop), 1);
    res_ready  = 1'b1;
    prod_valid = 1'b1;
    prod       = 8'd2;
    push(9, 0);
    step();
    prod_valid = 1'b0;
    chk_eq("bp_first_cnt", int'(term_cnt), 1);
    chk_eq("bp_valid_drop", int'(res_valid), 0);
    for (int i = 0; i < 7; i++) send(1, i % 2);
    step();
    chk_eq("bp_drop_sticky", int'(drop), 1);

    // Clear mid-sum beats a simultaneous product.
    repeat (4) send(5, 0);
    chk_eq("clr_cnt4", int'(term_cnt), 4);
    clear      = 1'b1;
    prod_valid = 1'b1;
    prod       = 8'd6;
    step();
    clear      = 1'b0;
    prod_valid = 1'b0;
    chk_eq("clr_cnt", int'(term_cnt), 0);
    chk_eq("clr_drop", int'(drop), 0);
    chk_eq("clr_valid", int'(res_valid), 0);
    chk_eq("clr_ready", int'(prod_ready), 1);
    push(8, 0);
    repeat (8) send(1, 0);
    step();

    // Asynchronous reset between edges while accumulating.
    repeat (5) send(10, 0);
    chk_eq("ar_cnt5", int'(term_cnt), 5);
    #2;
    rst = 1'b0;
    #1;
    chk_eq("ar_cnt", int'(term_cnt), 0);
    chk_eq("ar_valid", int'(res_valid), 0);
    chk_eq("ar_sum", int'(res_sum), 0);
    chk_eq("ar_ovf", int'(res_ovf), 0);
    chk_eq("ar_drop", int'(drop), 0);
    step();
    rst = 1'b1;
    push(-8, 0);
    repeat (8) send(-1, 1);
    repeat (2) step();

    // N_TERMS=1 build: one result per accepted product, back to back.
    res_ready1 = 1'b1;
    foreach (vals1[i]) begin
      exp_t e;
      e.sum = vals1[i];
      e.ovf = 0;
      exp1_q.push_back(e);
    end
    foreach (vals1[i]) begin
      prod_valid1 = 1'b1;
      prod1       = 8'(vals1[i]);
      step();
      chk_eq("n1_valid", int'(res_valid1), 1);
      chk_eq("n1_cnt", int'(term_cnt1), 1);
    end
    prod_valid1 = 1'b0;
    step();
    chk_eq("n1_retired", int'(res_valid1), 0);

    repeat (3) step();
    chk_eq("sb_drained", exp_q.size(), 0);
    chk_eq("sb1_drained", exp1_q.size(), 0);
    chk_eq("n_results", n_res, 7);
    chk_eq("n1_results", n_res1, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
